pass_sequencer: RTL and testbench
=================================

// Module: pass_sequencer
// PURPOSE
//  Downstream companion of the training state machine. Turns the f0/f1/b pass levels into
//  per-step MAC / weight-update strobes and a step index. Returns the single-cycle
//  f_end / b_end pulses and the zero_end_check level that move the state machine forward.
//  Tracks the epoch count and consecutive zero-loss passes to decide when training halts.
// PARAMETERS
//  F_STEPS    6    forward-pass steps: hidden MACs plus output MACs
//  B_STEPS    6    backward-pass steps: one weight update per step
//  STEP_W     3    step index width; must satisfy 2**STEP_W >= max(F_STEPS,B_STEPS)
//  LOSS_W     8    loss word width
//  ZERO_HITS  2    consecutive zero-loss forward passes that request halt
//  EPOCH_W    8    epoch counter width
//  MAX_EPOCH  255  epoch count that forces halt
// PORTS
//  clk_i             in   1        clock
//  rst_i             in   1        reset: synchronous, active-high
//  en_i              in   1        clock enable; when low, all state and outputs hold
//  f0_pass_i         in   1        first forward pass active (level)
//  f1_pass_i         in   1        later forward pass active (level)
//  b_pass_i          in   1        backward pass active (level)
//  loss_i            in   LOSS_W   loss of the current forward pass
//  loss_valid_i      in   1        loss_i valid strobe
//  step_o            out  STEP_W   current step index
//  mac_en_o          out  1        forward MAC strobe for step_o
//  wupd_en_o         out  1        weight-update strobe for step_o
//  f_end_o           out  1        1-cycle pulse: forward pass complete
//  b_end_o           out  1        1-cycle pulse: backward pass complete
//  zero_end_check_o  out  1        halt request (level, sticky)
//  epoch_o           out  EPOCH_W  completed backward passes
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): state IDLE; step, epoch and zero-hit counters = 0;
//    all strobes, pulses and zero_end_check_o = 0.
//  - Reset wins over en_i. Reset mid-pass aborts with no end pulse.
//  - en_i=0: nothing updates. Registered outputs hold their values; pulses are not re-issued.
//  - All outputs are registered.
//  - States:
//    - IDLE: f0|f1 -> FWD (step=0). Else b -> BWD (step=0). Forward has priority.
//      f1 with halt_req set -> HALT; no steps run.
//    - FWD: mac_en_o=1 for steps 0..F_STEPS-1, step_o increments each cycle.
//      After step F_STEPS-1: f_end_o=1 for one cycle, then WAIT.
//    - BWD: same pattern with wupd_en_o for steps 0..B_STEPS-1. Then b_end_o=1 for one cycle,
//      epoch_o+1 (saturating at MAX_EPOCH), then WAIT.
//    - WAIT: stay until the pass that just ended drops, then IDLE.
//      Guarantees one sequence per pass level.
//    - HALT: zero_end_check_o=1, all strobes 0. Exit only by reset.
//  - Latency: pass level seen at edge N -> first strobe at N+1.
//    f_end_o at N+F_STEPS+1; b_end_o at N+B_STEPS+1.
//  - Loss tracking: loss_valid_i is sampled only in FWD/WAIT after a forward pass.
//    - loss_i==0: zero_hits+1, saturating at ZERO_HITS.
//    - Otherwise: zero_hits=0.
//    - loss_valid_i outside a forward pass is ignored.
//  - halt_req = (zero_hits==ZERO_HITS) | (epoch_o==MAX_EPOCH). Evaluated on IDLE entry to f1.
//  - zero_end_check_o is never high in the same cycle as f_end_o.
//  - b_pass_i during FWD (and f during BWD) is ignored until WAIT/IDLE.
//  - Step counter wraps to 0 at pass end and never exceeds the pass step count.
// STRUCTURE
//  - Shared package: state encoding (IDLE/FWD/BWD/WAIT/HALT) and the F_STEPS/B_STEPS defaults,
//    so the state machine and datapath use identical step counts.
//  - One sub-module: step_counter. It provides a load-zero counter with a terminal-count
//    flag and is reused for the forward and backward step index.
//  - Epoch and zero-hit counters are kept inline.
// TESTING
//  - Reset: drive rst_i=1 for 2 cycles with f0_pass_i=1 -> all outputs 0, state IDLE.
//  - f0_pass_i=1 -> mac_en_o high 6 cycles, step_o 0..5.
//    f_end_o pulses exactly once at cycle 7. No second run while f0 stays high.
//  - b_pass_i=1 -> wupd_en_o 6 cycles, b_end_o pulses once, epoch_o 0->1.
//  - Loss: loss_i=0 valid in two forward passes, then f1_pass_i=1 ->
//    zero_end_check_o=1 and stays 1, mac_en_o and f_end_o stay 0.
//  - Zero-hit reset: loss=0, then loss=5, then loss=0, then f1 ->
//    normal 6-step pass, zero_end_check_o=0.
//  - en_i low for 3 cycles mid-FWD at step 2 -> step_o holds 2, f_end_o delayed by 3 cycles.
//    rst_i at step 4 -> IDLE, no f_end_o.

Source files
------------

// File: rtl/pass_sequencer_pkg.sv
// Shared constants and state encoding for the pass sequencer and its step counter.
package pass_sequencer_pkg;

  localparam int F_STEPS   = 6;
  localparam int B_STEPS   = 6;
  localparam int STEP_W    = 3;
  localparam int LOSS_W    = 8;
  localparam int ZERO_HITS = 2;
  localparam int EPOCH_W   = 8;
  localparam int MAX_EPOCH = 255;

  localparam int ZH_W = $clog2(ZERO_HITS + 1);

  localparam logic [STEP_W-1:0]  F_LAST    = STEP_W'(F_STEPS - 1);
  localparam logic [STEP_W-1:0]  B_LAST    = STEP_W'(B_STEPS - 1);
  localparam logic [ZH_W-1:0]    ZH_MAX    = ZH_W'(ZERO_HITS);
  localparam logic [EPOCH_W-1:0] EPOCH_MAX = EPOCH_W'(MAX_EPOCH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_BWD,
    ST_WAIT,
    ST_HALT
  } seq_state_t;

endpackage

// File: rtl/pass_sequencer_if.sv
// Pass levels and loss from the training state machine, strobes and status back to it.
interface pass_sequencer_if;
  import pass_sequencer_pkg::*;

  logic               f0_pass_i;
  logic               f1_pass_i;
  logic               b_pass_i;
  logic [LOSS_W-1:0]  loss_i;
  logic               loss_valid_i;
  logic [STEP_W-1:0]  step_o;
  logic               mac_en_o;
  logic               wupd_en_o;
  logic               f_end_o;
  logic               b_end_o;
  logic               zero_end_check_o;
  logic [EPOCH_W-1:0] epoch_o;

  modport master (
    output f0_pass_i, f1_pass_i, b_pass_i, loss_i, loss_valid_i,
    input  step_o, mac_en_o, wupd_en_o, f_end_o, b_end_o, zero_end_check_o, epoch_o
  );

  modport slave (
    input  f0_pass_i, f1_pass_i, b_pass_i, loss_i, loss_valid_i,
    output step_o, mac_en_o, wupd_en_o, f_end_o, b_end_o, zero_end_check_o, epoch_o
  );

endinterface

// File: rtl/pass_sequencer_step_counter.sv
// Load-zero step counter with a terminal-count flag; the terminal value is chosen per pass.
module pass_sequencer_step_counter
  import pass_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [STEP_W-1:0] last_i,
  output logic [STEP_W-1:0] cnt_o,
  output logic              tc_o
);

  // Clear has priority so the index wraps to 0 on the terminal step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        cnt_o <= '0;
      end else if (inc_i) begin
        cnt_o <= cnt_o + 1'b1;
      end
    end
  end

  assign tc_o = (cnt_o == last_i);

endmodule

// File: rtl/pass_sequencer.sv
// Pass sequencer: turns training pass levels into per-step strobes, end pulses,
// epoch count and a sticky halt request.
//
// state | meaning
// IDLE  | waiting for a pass level; forward beats backward
// FWD   | forward MAC strobes, one step per enabled cycle
// BWD   | weight-update strobes, one step per enabled cycle
// WAIT  | pass finished; hold until the level of that pass drops
// HALT  | training done; zero_end_check_o held until reset
module pass_sequencer
  import pass_sequencer_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  pass_sequencer_if.slave bus
);

  seq_state_t         state;
  logic               last_fwd;
  logic               mac_en;
  logic               wupd_en;
  logic               f_end;
  logic               b_end;
  logic               zero_end_check;
  logic [EPOCH_W-1:0] epoch;
  logic [ZH_W-1:0]    zero_hits;
  logic [STEP_W-1:0]  step;
  logic [STEP_W-1:0]  step_last;
  logic               step_tc;
  logic               step_clr;
  logic               in_pass;
  logic               fwd_lvl;
  logic               halt_req;
  logic               loss_window;

  assign fwd_lvl     = bus.f0_pass_i | bus.f1_pass_i;
  assign in_pass     = (state == ST_FWD) | (state == ST_BWD);
  assign step_last   = (state == ST_BWD) ? B_LAST : F_LAST;
  assign step_clr    = (state == ST_IDLE) | (in_pass & step_tc);
  assign halt_req    = (zero_hits == ZH_MAX) | (epoch == EPOCH_MAX);
  // Loss belongs to the forward pass only: while it runs or while its level is still held.
  assign loss_window = (state == ST_FWD) | ((state == ST_WAIT) & last_fwd);

  pass_sequencer_step_counter u_step_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .clr_i  (step_clr),
    .inc_i  (in_pass),
    .last_i (step_last),
    .cnt_o  (step),
    .tc_o   (step_tc)
  );

  // Pass sequencing, registered strobes/pulses and epoch count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      last_fwd       <= 1'b0;
      mac_en         <= 1'b0;
      wupd_en        <= 1'b0;
      f_end          <= 1'b0;
      b_end          <= 1'b0;
      zero_end_check <= 1'b0;
      epoch          <= '0;
    end else if (en_i) begin
      f_end <= 1'b0;
      b_end <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.f1_pass_i && halt_req) begin
            state          <= ST_HALT;
            zero_end_check <= 1'b1;
          end else if (fwd_lvl) begin
            state    <= ST_FWD;
            mac_en   <= 1'b1;
            last_fwd <= 1'b1;
          end else if (bus.b_pass_i) begin
            state    <= ST_BWD;
            wupd_en  <= 1'b1;
            last_fwd <= 1'b0;
          end
        end
        ST_FWD: begin
          if (step_tc) begin
            state  <= ST_WAIT;
            mac_en <= 1'b0;
            f_end  <= 1'b1;
          end
        end
        ST_BWD: begin
          if (step_tc) begin
            state   <= ST_WAIT;
            wupd_en <= 1'b0;
            b_end   <= 1'b1;
            if (epoch != EPOCH_MAX) begin
              epoch <= epoch + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (last_fwd ? !fwd_lvl : !bus.b_pass_i) begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          zero_end_check <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Consecutive zero-loss forward passes, saturating at the halt threshold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zero_hits <= '0;
    end else if (en_i && loss_window && bus.loss_valid_i) begin
      if (bus.loss_i != '0) begin
        zero_hits <= '0;
      end else if (zero_hits != ZH_MAX) begin
        zero_hits <= zero_hits + 1'b1;
      end
    end
  end

  assign bus.step_o           = step;
  assign bus.mac_en_o         = mac_en;
  assign bus.wupd_en_o        = wupd_en;
  assign bus.f_end_o          = f_end;
  assign bus.b_end_o          = b_end;
  assign bus.zero_end_check_o = zero_end_check;
  assign bus.epoch_o          = epoch;

endmodule

// File: tb/tb_pass_sequencer.sv
// Bench for pass_sequencer: pass-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pass_sequencer;
  import pass_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  pass_sequencer_if bus ();

  pass_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 running a pass, 2 pass done waiting for its level to drop, 3 halted.
  int m_phase = 0;
  int m_kind  = 0;   // 1 forward, 2 backward
  int m_pos   = 0;   // strobes already issued in the running pass
  int m_zh    = 0;
  int m_ep    = 0;
  bit m_pulse = 0;
  bit m_ok    = 0;
  bit m_fwd_lvl;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_kind = 0; m_pos = 0; m_zh = 0; m_ep = 0; m_pulse = 0; m_ok = 1;
    end else if (en) begin
      m_fwd_lvl = bus.f0_pass_i || bus.f1_pass_i;
      if (bus.loss_valid_i && m_kind == 1 && (m_phase == 1 || m_phase == 2))
        m_zh = (bus.loss_i == 0) ? ((m_zh < ZERO_HITS) ? m_zh + 1 : m_zh) : 0;
      m_pulse = 0;
      if (m_phase == 0) begin
        if (bus.f1_pass_i && (m_zh >= ZERO_HITS || m_ep >= MAX_EPOCH)) m_phase = 3;
        else if (m_fwd_lvl) begin m_phase = 1; m_kind = 1; m_pos = 0; end
        else if (bus.b_pass_i) begin m_phase = 1; m_kind = 2; m_pos = 0; end
      end else if (m_phase == 1) begin
        m_pos++;
        if (m_pos == ((m_kind == 1) ? F_STEPS : B_STEPS)) begin
          m_phase = 2; m_pulse = 1; m_pos = 0;
          if (m_kind == 2 && m_ep < MAX_EPOCH) m_ep++;
        end
      end else if (m_phase == 2) begin
        if ((m_kind == 1) ? !m_fwd_lvl : !bus.b_pass_i) m_phase = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      cmp("step",      32'(bus.step_o),           32'((m_phase == 1) ? m_pos : 0));
      cmp("mac_en",    32'(bus.mac_en_o),         32'(m_phase == 1 && m_kind == 1));
      cmp("wupd_en",   32'(bus.wupd_en_o),        32'(m_phase == 1 && m_kind == 2));
      cmp("f_end",     32'(bus.f_end_o),          32'(m_pulse && m_kind == 1));
      cmp("b_end",     32'(bus.b_end_o),          32'(m_pulse && m_kind == 2));
      cmp("zero_end",  32'(bus.zero_end_check_o), 32'(m_phase == 3));
      cmp("epoch",     32'(bus.epoch_o),          32'(m_ep));
      if (bus.zero_end_check_o && bus.f_end_o) cmp("zec_with_fend", 32'd1, 32'd0);
    end
  end

  // Directed-scenario observation counters, sampled by the stimulus itself.
  int cyc, w_mac, w_wupd, w_fend, w_bend, w_zec, w_fend_at, w_bend_at;

  task automatic clr_watch();
    cyc = 0; w_mac = 0; w_wupd = 0; w_fend = 0; w_bend = 0; w_zec = 0;
    w_fend_at = -1; w_bend_at = -1;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.mac_en_o === 1'b1) w_mac++;
    if (bus.wupd_en_o === 1'b1) w_wupd++;
    if (bus.zero_end_check_o === 1'b1) w_zec++;
    if (bus.f_end_o === 1'b1) begin w_fend++; w_fend_at = cyc; end
    if (bus.b_end_o === 1'b1) begin w_bend++; w_bend_at = cyc; end
  endtask

  task automatic fwd_with_loss(input bit use_f1, input int lossv);
    if (use_f1) bus.f1_pass_i = 1'b1; else bus.f0_pass_i = 1'b1;
    repeat (8) tick();
    bus.loss_valid_i = 1'b1;
    bus.loss_i       = LOSS_W'(lossv);
    tick();
    bus.loss_valid_i = 1'b0;
    bus.f0_pass_i    = 1'b0;
    bus.f1_pass_i    = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.f0_pass_i = 1'b1; bus.f1_pass_i = 1'b0; bus.b_pass_i = 1'b0;
    bus.loss_i = '0; bus.loss_valid_i = 1'b0;
    clr_watch();

    // Reset held two cycles with f0 high: everything quiet.
    repeat (2) tick();
    cmp("rst_mac",   32'(bus.mac_en_o), 32'd0);
    cmp("rst_step",  32'(bus.step_o), 32'd0);
    cmp("rst_zec",   32'(bus.zero_end_check_o), 32'd0);
    cmp("rst_epoch", 32'(bus.epoch_o), 32'd0);
    rst = 1'b0; bus.f0_pass_i = 1'b0;
    repeat (2) tick();

    // Forward pass held long: one sequence only.
    clr_watch();
    bus.f0_pass_i = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i <= 6) cmp("fwd_step_seq", 32'(bus.step_o), 32'(i - 1));
    end
    cmp("fwd_mac_cycles", w_mac, 6);
    cmp("fwd_fend_count", w_fend, 1);
    cmp("fwd_fend_cycle", w_fend_at, 7);
    bus.f0_pass_i = 1'b0;
    repeat (2) tick();

    // Backward pass: six updates, one end pulse, epoch 0 -> 1.
    clr_watch();
    bus.b_pass_i = 1'b1;
    repeat (10) tick();
    cmp("bwd_wupd_cycles", w_wupd, 6);
    cmp("bwd_bend_count", w_bend, 1);
    cmp("bwd_bend_cycle", w_bend_at, 7);
    cmp("bwd_epoch", 32'(bus.epoch_o), 32'd1);
    bus.b_pass_i = 1'b0;
    repeat (2) tick();

    // Two zero-loss forward passes, then f1 halts without running steps.
    fwd_with_loss(1'b0, 0);
    fwd_with_loss(1'b1, 0);
    clr_watch();
    bus.f1_pass_i = 1'b1;
    repeat (10) tick();
    cmp("halt_mac_cycles", w_mac, 0);
    cmp("halt_fend_count", w_fend, 0);
    cmp("halt_zec_cycles", w_zec, 10);
    bus.f1_pass_i = 1'b0;
    repeat (3) tick();
    cmp("halt_sticky", 32'(bus.zero_end_check_o), 32'd1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    cmp("halt_cleared", 32'(bus.zero_end_check_o), 32'd0);

    // Zero-hit run broken by a nonzero loss; idle loss strobe must be ignored.
    fwd_with_loss(1'b0, 0);
    fwd_with_loss(1'b1, 5);
    bus.loss_valid_i = 1'b1; bus.loss_i = '0;
    tick();
    bus.loss_valid_i = 1'b0;
    fwd_with_loss(1'b0, 0);
    clr_watch();
    bus.f1_pass_i = 1'b1;
    repeat (9) tick();
    cmp("zh_reset_mac_cycles", w_mac, 6);
    cmp("zh_reset_fend_count", w_fend, 1);
    cmp("zh_reset_zec_cycles", w_zec, 0);
    bus.f1_pass_i = 1'b0;
    repeat (2) tick();

    // Enable low for three cycles at step 2 delays the end pulse by three.
    clr_watch();
    bus.f0_pass_i = 1'b1;
    repeat (3) tick();
    cmp("en_step_before", 32'(bus.step_o), 32'd2);
    en = 1'b0;
    repeat (3) tick();
    cmp("en_step_held", 32'(bus.step_o), 32'd2);
    en = 1'b1;
    repeat (6) tick();
    cmp("en_mac_cycles", w_mac, 9);
    cmp("en_fend_cycle", w_fend_at, 10);
    bus.f0_pass_i = 1'b0;
    repeat (2) tick();

    // Reset at step 4 aborts the pass with no end pulse.
    clr_watch();
    bus.f0_pass_i = 1'b1;
    repeat (5) tick();
    cmp("abort_step_before", 32'(bus.step_o), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.f0_pass_i = 1'b0;
    repeat (10) tick();
    cmp("abort_fend_count", w_fend, 0);
    cmp("abort_mac_cycles", w_mac, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
